onehot_token_gen: RTL
=====================

// Module: onehot_token_gen
// PURPOSE
//  Sequential one-hot token generator: the producer side of the one-hot check.
//  Keeps a DATA_WIDTH-bit one-hot token and presents it on a valid/ready stream.
//  Rotates the token one position per accepted transfer. Supports a binary-index
//  load and a sticky self-check. Drives arbiter grants and ring-slot selects.
// PARAMETERS
//  DATA_WIDTH  32  token width in bits, >=2; IDX_W = $clog2(DATA_WIDTH) is derived
//  RESET_IDX   0   bit position set in the token at reset, < DATA_WIDTH
//  CNT_W       16  width of the accepted-token counter
// PORTS
//  clk         in   1           single clock, rising edge
//  resetn      in   1           asynchronous, active-low reset
//  step_en     in   1           request token streaming
//  dir         in   1           0: rotate toward MSB; 1: rotate toward LSB
//  load_valid  in   1           load request
//  load_idx    in   IDX_W       binary bit position to load
//  load_ready  out  1           load accepted when load_valid & load_ready
//  tok_valid   out  1           token presented
//  tok_ready   in   1           consumer accepts token
//  tok_data    out  DATA_WIDTH  one-hot token
//  tok_idx     out  IDX_W       binary index of tok_data, always consistent with it
//  tok_cnt     out  CNT_W       number of accepted tokens, wraps modulo 2^CNT_W
//  wrap        out  1           1-cycle pulse when the token rotates past an end
//  err         out  1           sticky error flag
// BEHAVIOUR
//  Reset (async assert, sync deassert at clk): state IDLE; tok_valid=0;
//   tok_data=1<<RESET_IDX; tok_idx=RESET_IDX; tok_cnt=0; wrap=0; err=0.
//  FSM states:
//   IDLE: tok_valid=0, load_ready=1.
//    - step_en=1 -> RUN next cycle.
//   RUN: tok_valid=1, load_ready=0.
//    - Handshake (tok_valid&tok_ready) with step_en=1 -> stay RUN.
//    - Handshake with step_en=0 -> IDLE.
//  Stall rule: while tok_valid & !tok_ready, tok_data and tok_idx hold stable.
//   tok_valid never drops without a handshake.
//  Advance on each handshake, one cycle latency:
//   - dir=0: rotate left; tok_idx+1; bit DATA_WIDTH-1 -> bit 0.
//   - dir=1: rotate right; tok_idx-1; bit 0 -> bit DATA_WIDTH-1.
//   - tok_cnt += 1.
//   - wrap=1 in the cycle the wrapped token appears; otherwise wrap=0.
//   - dir is sampled at the handshake edge only.
//  Load (IDLE only):
//   - In-range load_idx: next cycle tok_data=1<<load_idx, tok_idx=load_idx.
//   - load_idx>=DATA_WIDTH (non-power-of-2 widths): rejected, token unchanged, err=1.
//   - load with step_en=1 in the same cycle: load applies; RUN presents the
//     loaded token first.
//   - load does not change tok_cnt or wrap.
//  Self-check: err set if the token register is not exactly one-hot (popcount!=1)
//   or tok_idx disagrees with tok_data. err clears only on reset.
//  Reset mid-transfer (RUN, stalled): outputs go to reset values immediately.
//   The pending token is dropped, not replayed.
// STRUCTURE
//  Package onehot_pkg:
//   - typedef enum logic {IDLE, RUN} tokgen_state_e
//   - function rotl1/rotr1(DATA_WIDTH)
//   - shared IDX_W derivation
//  Sub-module onehot_chk: combinational popcount==1 check on the token register.
//   Output feeds the err logic.
//  Top level holds the FSM, token/index/count registers and the wrap pulse.
//  All outputs are registered except load_ready (decoded from state).
// TESTING (DATA_WIDTH=8 unless noted)
//  1. Reset, step_en=1, tok_ready=1:
//     tok_data 0x01,0x02,...,0x80,0x01; wrap=1 only with the second 0x01; tok_cnt=8 then.
//  2. tok_data=0x04, tok_ready=0 for 3 cycles:
//     0x04 and tok_valid=1 hold; after ready, next token 0x08, tok_idx=3.
//  3. dir=1 from 0x01:
//     next 0x80, tok_idx=7, wrap=1; then 0x40.
//  4. IDLE, load_idx=5:
//     tok_data=0x20, tok_idx=5.
//     DATA_WIDTH=6, load_idx=7: token unchanged, err=1 and stays 1.
//  5. resetn low while RUN stalled on 0x10:
//     tok_valid=0 and tok_data=0x01 without a clk edge; tok_cnt=0.
//  6. step_en=0 at handshake on 0x02:
//     IDLE next cycle, tok_valid=0, tok_data=0x04 held.

Source files
------------

// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot token generator.
//   tokgen_state_e : producer FSM state (IDLE / RUN)
//   idx_width()    : width of a binary index into a DATA_WIDTH-bit token
//   rotl1/rotr1    : single-position rotate of the low w bits of a MAX_W vector
// Token widths up to MAX_W bits are supported by the rotate helpers.
package onehot_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tokgen_state_e;

    localparam int unsigned MAX_W = 256;

    function automatic int unsigned idx_width(input int unsigned dw);
        return (dw > 2) ? $clog2(dw) : 1;
    endfunction

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
        return (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    endfunction

    // Bit w-1 wraps to bit 0.
    function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v,
                                               input int unsigned       w);
        return ((v << 1) | (v >> (w - 1))) & width_mask(w);
    endfunction

    // Bit 0 wraps to bit w-1.
    function automatic logic [MAX_W-1:0] rotr1(input logic [MAX_W-1:0] v,
                                               input int unsigned       w);
        return ((v >> 1) | (v << (w - 1))) & width_mask(w);
    endfunction

endpackage

// File: rtl/onehot_chk.sv
// Combinational one-hot check: onehot_o is 1 when exactly one bit of vec_i
// is set (popcount == 1).
//   vec_i    in  DATA_WIDTH  vector under test
//   onehot_o out 1           popcount(vec_i) == 1
module onehot_chk #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] vec_i,
    output logic                  onehot_o
);

    logic seen_one;
    logic seen_two;

    // Saturating popcount: only "at least one" and "at least two" matter.
    always_comb begin
        seen_one = 1'b0;
        seen_two = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            seen_two = seen_two | (seen_one & vec_i[i]);
            seen_one = seen_one | vec_i[i];
        end
        onehot_o = seen_one & ~seen_two;
    end

endmodule

// File: rtl/onehot_token_gen.sv
// One-hot token producer. Holds a DATA_WIDTH-bit one-hot token and presents it
// on a valid/ready stream, rotating it one position per accepted transfer.
// A binary-index load is accepted while idle; a sticky error flags rejected
// loads and any loss of one-hot/index consistency in the token register.
//   clk        in   1           rising-edge clock
//   resetn     in   1           async assert, active-low; released on a clk edge
//   step_en    in   1           request token streaming
//   dir        in   1           0: rotate toward MSB, 1: rotate toward LSB
//   load_valid in   1           load request
//   load_idx   in   IDX_W       bit position to load
//   load_ready out  1           load accepted (high while idle)
//   tok_valid  out  1           token presented
//   tok_ready  in   1           consumer accepts token
//   tok_data   out  DATA_WIDTH  one-hot token
//   tok_idx    out  IDX_W       binary index of tok_data
//   tok_cnt    out  CNT_W       accepted-token count, wraps
//   wrap       out  1           pulse when the token rotates past an end
//   err        out  1           sticky error
module onehot_token_gen
    import onehot_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned RESET_IDX  = 0,
    parameter  int unsigned CNT_W      = 16,
    localparam int unsigned IDX_W      = idx_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  step_en,
    input  logic                  dir,
    input  logic                  load_valid,
    input  logic [IDX_W-1:0]      load_idx,
    output logic                  load_ready,
    output logic                  tok_valid,
    input  logic                  tok_ready,
    output logic [DATA_WIDTH-1:0] tok_data,
    output logic [IDX_W-1:0]      tok_idx,
    output logic [CNT_W-1:0]      tok_cnt,
    output logic                  wrap,
    output logic                  err
);

    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] RST_TOK  = ONE << RESET_IDX;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    // Reset synchroniser: assertion reaches the core flops immediately,
    // release is aligned to clk.
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    tokgen_state_e         state_q, state_d;
    logic [DATA_WIDTH-1:0] tok_q, tok_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wrap_q, wrap_d;
    logic                  err_q, err_d;

    logic tok_onehot;
    logic idx_bad;
    logic load_in_range;

    onehot_chk #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_chk (
        .vec_i   (tok_q),
        .onehot_o(tok_onehot)
    );

    assign idx_bad       = (tok_q != (ONE << idx_q));
    assign load_in_range = (32'(load_idx) < DATA_WIDTH);

    always_comb begin
        state_d = state_q;
        tok_d   = tok_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        err_d   = err_q | ~tok_onehot | idx_bad;

        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    if (load_in_range) begin
                        tok_d = ONE << load_idx;
                        idx_d = load_idx;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (step_en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tok_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!dir) begin
                        tok_d  = DATA_WIDTH'(rotl1(MAX_W'(tok_q), DATA_WIDTH));
                        idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                        wrap_d = (idx_q == LAST_IDX);
                    end else begin
                        tok_d  = DATA_WIDTH'(rotr1(MAX_W'(tok_q), DATA_WIDTH));
                        idx_d  = (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
                        wrap_d = (idx_q == '0);
                    end
                    state_d = step_en ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= IDLE;
            tok_q   <= RST_TOK;
            idx_q   <= IDX_W'(RESET_IDX);
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tok_q   <= tok_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign load_ready = (state_q == IDLE);
    assign tok_valid  = (state_q == RUN);
    assign tok_data   = tok_q;
    assign tok_idx    = idx_q;
    assign tok_cnt    = cnt_q;
    assign wrap       = wrap_q;
    assign err        = err_q;

endmodule
